soma_scan_ctrl: RTL

- Initiator side of the soma update interface: once per timestep, sweeps neuron addresses 0..N-1 by driving config_soma_vld, config_soma_vm_addr and config_soma_clear.
- Issues the matching dendrite (SD) read so the accumulated input lines up with the soma membrane read.
- Samples soma_spk_out_fire one cycle after each issue and queues fired neuron IDs into a small FIFO drained by the spike-out/axon stage over valid/ready.
- Sits between the node timestep controller and the soma.

---
 rtl/soma_pkg.sv | 6 +
 rtl/spk_fifo.sv | 40 ++++
 rtl/soma_scan_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/soma_pkg.sv
// soma_pkg: shared widths and scan FSM states for the soma scan controller
package soma_pkg;
  localparam int NNW = 12;
  localparam int FD = 3;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
endpackage

// File: rtl/spk_fifo.sv
// spk_fifo: synchronous FIFO of fired neuron IDs with combinational head read
module spk_fifo #(
  parameter int W = 12,
  parameter int AW = 3
) (
  input  logic          clk_soma,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full
);
  logic [W-1:0] mem [2**AW];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  always_comb begin
    do_push = push && !full;
    do_pop = pop && !empty;
    empty = count == '0;
    full = count[AW];
    dout = mem[rd];
  end
  // pointers and occupancy; pop on empty is a no-op
  always_ff @(posedge clk_soma or negedge rst_n)
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // storage needs no reset; only written entries are ever read
  always_ff @(posedge clk_soma)
    if (do_push) mem[wr] <= din;
endmodule

// File: rtl/soma_scan_ctrl.sv
// soma_scan_ctrl: per-timestep soma sweep with SD read issue and fired-ID FIFO
module soma_scan_ctrl
  import soma_pkg::*;
(
  input  logic           clk_soma,
  input  logic           rst_n,
  input  logic           tick_start,
  input  logic [NNW:0]   cfg_neuron_num,
  input  logic           cfg_clear_mode,
  output logic           config_soma_vld,
  output logic [NNW-1:0] config_soma_vm_addr,
  output logic           config_soma_clear,
  output logic           sd_re,
  output logic [NNW-1:0] sd_raddr,
  input  logic           soma_spk_out_fire,
  output logic           spk_valid,
  output logic [NNW-1:0] spk_nid,
  input  logic           spk_ready,
  output logic           scan_busy,
  output logic           scan_done,
  output logic [NNW:0]   fired_cnt
);
  state_t state, state_nx;
  logic [NNW:0] cnt, num_q;
  logic [NNW-1:0] addr_d;
  logic [FD:0] count;
  logic clr_q, vld_d, clear_d, issue, start, push, empty, full;
  // issue only with two free slots: one for this request, one for the result already in flight
  always_comb begin
    start = state == IDLE && tick_start;
    issue = state == SCAN && count <= (FD+1)'(2**FD - 2);
    push = vld_d && !clear_d && soma_spk_out_fire && !full;
    config_soma_vld = issue;
    config_soma_vm_addr = cnt[NNW-1:0];
    config_soma_clear = issue && clr_q;
    sd_re = issue && !clr_q;
    sd_raddr = cnt[NNW-1:0];
    spk_valid = !empty;
    scan_busy = state == SCAN || state == DRAIN;
    scan_done = state == DONE;
    state_nx = state;
    case (state)
      IDLE: if (tick_start) state_nx = cfg_neuron_num != '0 ? SCAN : DONE;
      SCAN: if (issue && cnt == num_q - (NNW+1)'(1)) state_nx = DRAIN;
      DRAIN: state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  // FSM state register
  always_ff @(posedge clk_soma or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // sweep configuration latch and address counter
  always_ff @(posedge clk_soma or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      num_q <= '0;
      clr_q <= 1'b0;
    end else if (start) begin
      cnt <= '0;
      num_q <= cfg_neuron_num;
      clr_q <= cfg_clear_mode;
    end else if (issue) cnt <= cnt + 1'b1;
  // track the issue one cycle so the fire result pairs with its address
  always_ff @(posedge clk_soma or negedge rst_n)
    if (!rst_n) begin
      vld_d <= 1'b0;
      clear_d <= 1'b0;
      addr_d <= '0;
      fired_cnt <= '0;
    end else begin
      vld_d <= issue;
      clear_d <= config_soma_clear;
      addr_d <= cnt[NNW-1:0];
      if (start && cfg_neuron_num != '0) fired_cnt <= '0;
      else if (push) fired_cnt <= fired_cnt + 1'b1;
    end
  spk_fifo #(.W(NNW), .AW(FD)) u_fifo (
    .clk_soma(clk_soma),
    .rst_n(rst_n),
    .push(push),
    .din(addr_d),
    .pop(spk_valid && spk_ready),
    .dout(spk_nid),
    .count(count),
    .empty(empty),
    .full(full)
  );
endmodule
